// File: rtl/stack_unit.sv
// Register/RAM storage for one CPU stack (data or return), fed by the ALU.
// Optional depth guard (count register, sticky overflow/underflow) enabled by STACK_GUARD_EN.
module stack_unit #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HAS_TOP_REG = 1
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             advance,
  input  logic [DEPTH-1:0] pointer_next,
  input  logic [WIDTH-1:0] next_top,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] write_data,
  input  logic             guard_clear,
  output logic [DEPTH-1:0] pointer_top,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned ENTRIES = 2 ** DEPTH;

  logic [DEPTH-1:0] pointer_q;
  logic [WIDTH-1:0] ram [ENTRIES];

  // Pointer register and stack RAM; a write lands at the incoming pointer.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      pointer_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ram[i] <= '0;
    end else if (advance) begin
      pointer_q <= pointer_next;
      if (write_enable) ram[pointer_next] <= write_data;
    end
  end

  assign pointer_top = pointer_q;

  if (HAS_TOP_REG != 0) begin : g_top_reg
    logic [WIDTH-1:0] top_q;

    always_ff @(posedge clk or negedge resetq) begin
      if (!resetq)      top_q <= '0;
      else if (advance) top_q <= next_top;
    end

    assign top    = top_q;
    assign second = ram[pointer_q];
  end else begin : g_top_ram
    logic [WIDTH-1:0] unused_next_top;

    assign unused_next_top = next_top;
    assign top             = ram[pointer_q];
    assign second          = ram[pointer_q - DEPTH'(1)];
  end

`ifdef STACK_GUARD_EN
  localparam logic signed [DEPTH+1:0] CNT_MAX = (DEPTH + 2)'(ENTRIES - 1);

  logic [DEPTH:0]          count_q;
  logic                    overflow_q;
  logic                    underflow_q;
  logic signed [DEPTH-1:0] delta;
  logic signed [DEPTH+1:0] sum;
  logic                    sum_neg;
  logic                    sum_big;

  // Pointer movement read as a signed step; the count is widened so both limits are visible.
  assign delta   = $signed(pointer_next - pointer_q);
  assign sum     = $signed({1'b0, count_q}) + (DEPTH + 2)'(delta);
  assign sum_neg = sum[DEPTH+1];
  assign sum_big = sum > CNT_MAX;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (advance) begin
        if (sum_neg)      count_q <= '0;
        else if (sum_big) count_q <= (DEPTH + 1)'(CNT_MAX);
        else              count_q <= sum[DEPTH:0];
      end
      // Clearing wins over a flag being raised on the same edge.
      if (guard_clear) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else if (advance) begin
        if (sum_big) overflow_q  <= 1'b1;
        if (sum_neg) underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_guard_clear;

  assign unused_guard_clear = guard_clear;
  assign overflow           = 1'b0;
  assign underflow          = 1'b0;
`endif

endmodule
